// File: rtl/jtag_dr_bridge.sv
// Bridge from the ECP5 JTAGG user data registers (ER1/ER2) into the clk domain.
// JTAG pins are oversampled; a Capture/Shift/Update engine feeds a valid/ready update port.
//
// state    | meaning
// ST_IDLE  | waiting for a Capture-DR rise on ER1/ER2
// ST_SHIFT | captured; shifting on jshift rises until jupdate
module jtag_dr_bridge #(
   parameter int DR_WIDTH    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jtck,
   input  logic                  jtdi,
   input  logic                  jshift,
   input  logic                  jupdate,
   input  logic                  jce1,
   input  logic                  jce2,
   input  logic                  jrstn,
   output logic                  jtdo1,
   output logic                  jtdo2,
   input  logic [2*DR_WIDTH-1:0] cap_data,
   output logic                  cap_ack,
   output logic                  cap_sel,
   output logic [DR_WIDTH-1:0]   upd_data,
   output logic                  upd_sel,
   output logic                  upd_valid,
   input  logic                  upd_ready,
   output logic                  err_short,
   output logic                  err_ovr
);

   localparam int CNT_W = $clog2(DR_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_WIDTH);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   logic [6:0] pins;
   logic [6:0] pins_s;
   assign pins = {jrstn, jce2, jce1, jupdate, jshift, jtdi, jtck};

   for (genvar g = 0; g < 7; g++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      always_ff @(posedge clk) begin
         if (rst) chain_q <= '0;
         else     chain_q <= {chain_q[SYNC_STAGES-2:0], pins[g]};
      end
      assign pins_s[g] = chain_q[SYNC_STAGES-1];
   end

   logic tck_s, tdi_s, shift_s, update_s, ce1_s, ce2_s, rstn_s;
   assign {rstn_s, ce2_s, ce1_s, update_s, shift_s, tdi_s, tck_s} = pins_s;

   logic tck_d;
   logic rise, fall;
   assign rise = tck_s & ~tck_d;
   assign fall = ~tck_s & tck_d;

   state_t               state_q, state_d;
   logic [DR_WIDTH-1:0]  sr_q;
   logic [CNT_W-1:0]     bitcnt_q;
   logic                 shift_q;
   logic                 tdo_q;
   logic                 deliver_q;
   logic [DR_WIDTH-1:0]  pend_data_q;
   logic                 pend_sel_q;
   logic                 do_cap, do_shift, do_upd, do_short;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      do_cap   = 1'b0;
      do_shift = 1'b0;
      do_upd   = 1'b0;
      do_short = 1'b0;
      if (!rstn_s) begin
         state_d = ST_IDLE;
      end else if (rise) begin
         case (state_q)
            ST_IDLE: begin
               if ((ce1_s | ce2_s) && !shift_s) begin
                  do_cap  = 1'b1;
                  state_d = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (update_s) begin
                  state_d = ST_IDLE;
                  if (bitcnt_q == CNT_FULL) do_upd   = 1'b1;
                  else                      do_short = 1'b1;
               end else if (shift_q) begin
                  do_shift = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tck_d       <= 1'b0;
         sr_q        <= '0;
         bitcnt_q    <= '0;
         shift_q     <= 1'b0;
         tdo_q       <= 1'b0;
         deliver_q   <= 1'b0;
         pend_data_q <= '0;
         pend_sel_q  <= 1'b0;
         cap_ack     <= 1'b0;
         cap_sel     <= 1'b0;
         err_short   <= 1'b0;
      end else begin
         tck_d     <= tck_s;
         cap_ack   <= do_cap;
         err_short <= do_short;
         deliver_q <= do_upd;
         if (do_upd) begin
            pend_data_q <= sr_q;
            pend_sel_q  <= cap_sel;
         end
         if (!rstn_s) begin
            sr_q     <= '0;
            bitcnt_q <= '0;
            shift_q  <= 1'b0;
         end else begin
            if (rise) shift_q <= shift_s;
            if (do_cap) begin
               // ER2 takes priority when both enables are asserted
               sr_q     <= ce2_s ? cap_data[2*DR_WIDTH-1:DR_WIDTH] : cap_data[DR_WIDTH-1:0];
               cap_sel  <= ce2_s;
               bitcnt_q <= '0;
            end else if (do_shift) begin
               sr_q <= {tdi_s, sr_q[DR_WIDTH-1:1]};
               if (bitcnt_q != CNT_FULL) bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
         end
         if (fall) tdo_q <= sr_q[0];
      end
   end

   // A word arriving in the same cycle the consumer accepts replaces it without overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_data  <= '0;
         upd_sel   <= 1'b0;
         upd_valid <= 1'b0;
         err_ovr   <= 1'b0;
      end else if (deliver_q) begin
         if (!upd_valid || upd_ready) begin
            upd_data  <= pend_data_q;
            upd_sel   <= pend_sel_q;
            upd_valid <= 1'b1;
         end else begin
            err_ovr <= 1'b1;
         end
      end else if (upd_valid && upd_ready) begin
         upd_valid <= 1'b0;
      end
   end

   assign jtdo1 = tdo_q;
   assign jtdo2 = tdo_q;

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge: bit-banged JTAG scans with hand-computed results.
module tb_jtag_dr_bridge;
   localparam int W    = 32;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst, jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn;
   logic jtdo1, jtdo2;
   logic [2*W-1:0] cap_data;
   logic cap_ack, cap_sel;
   logic [W-1:0] upd_data;
   logic upd_sel, upd_valid, upd_ready, err_short, err_ovr;

   int checks = 0, errors = 0;
   int acc_cnt = 0, cap_cnt = 0, short_cnt = 0, valid_cyc = 0;
   logic [W-1:0] acc_data = '0;
   logic acc_sel = 1'b0;

   always #5 clk = ~clk;

   jtag_dr_bridge #(.DR_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
      .jupdate(jupdate), .jce1(jce1), .jce2(jce2), .jrstn(jrstn),
      .jtdo1(jtdo1), .jtdo2(jtdo2), .cap_data(cap_data), .cap_ack(cap_ack),
      .cap_sel(cap_sel), .upd_data(upd_data), .upd_sel(upd_sel),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .err_short(err_short),
      .err_ovr(err_ovr));

   always @(posedge clk) begin
      if (upd_valid && upd_ready) begin
         acc_cnt  = acc_cnt + 1;
         acc_data = upd_data;
         acc_sel  = upd_sel;
      end
      if (upd_valid) valid_cyc = valid_cyc + 1;
      if (cap_ack)   cap_cnt   = cap_cnt + 1;
      if (err_short) short_cnt = short_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic tck_edge(input logic lvl, output int lat);
      logic v0;
      v0   = upd_valid;
      lat  = 0;
      jtck = lvl;
      for (int i = 1; i <= HALF; i++) begin
         @(posedge clk); #1;
         if (upd_valid && !v0 && lat == 0) lat = i;
      end
   endtask

   // capture, n shifts (LSB first), update; returns early before shift abort_k
   task automatic scan(input logic ch1, input logic both, input int n,
                       input logic [63:0] din, input int abort_k,
                       output logic [63:0] tdo1_bits, output logic [63:0] tdo2_bits,
                       output int lat);
      int d;
      tdo1_bits = '0;
      tdo2_bits = '0;
      lat       = 0;
      jce1 = !ch1 || both; jce2 = ch1; jshift = 1'b0; jupdate = 1'b0;
      tck_edge(1'b1, d); tck_edge(1'b0, d);
      jshift = 1'b1;
      tck_edge(1'b1, d); tck_edge(1'b0, d);
      for (int k = 1; k <= n; k++) begin
         if (k == abort_k) return;
         jshift = (k < n);
         jtdi   = din[k-1];
         tdo1_bits[k-1] = jtdo1;
         tdo2_bits[k-1] = jtdo2;
         tck_edge(1'b1, d); tck_edge(1'b0, d);
      end
      jshift = 1'b0; jupdate = 1'b1;
      tck_edge(1'b1, lat); tck_edge(1'b0, d);
      jupdate = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jtdi = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; jtck = 0; jtdi = 0; jshift = 0; jupdate = 0; jce1 = 0; jce2 = 0;
      jrstn = 1'b1; upd_ready = 1'b0; cap_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({cap_ack, cap_sel, upd_sel, upd_valid, err_short, err_ovr, jtdo1, jtdo2} !== 8'h00) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000000",
            {cap_ack, cap_sel, upd_sel, upd_valid, err_short, err_ovr, jtdo1, jtdo2}); end
      checks++; if (upd_data !== '0) begin
         errors++; $display("FAIL reset_upd_data: got %h expected 0", upd_data); end
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_er1_write;
      logic [63:0] t1, t2; int lat, a0, c0, s0, v0;
      upd_ready = 1'b1;
      cap_data  = {32'h0BAD_F00D, 32'h1357_9BDF};
      a0 = acc_cnt; c0 = cap_cnt; s0 = short_cnt; v0 = valid_cyc;
      scan(1'b0, 1'b0, 32, 64'hDEAD_BEEF, 0, t1, t2, lat);
      checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL er1_accepts: got %0d expected 1", acc_cnt - a0); end
      checks++; if (acc_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL er1_data: got %h expected deadbeef", acc_data); end
      checks++; if (acc_sel !== 1'b0) begin errors++; $display("FAIL er1_sel: got %b expected 0", acc_sel); end
      checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL er1_valid_cycles: got %0d expected 1", valid_cyc - v0); end
      checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL er1_valid_clear: got %b expected 0", upd_valid); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL er1_latency: got %0d expected 4", lat); end
      checks++; if (short_cnt !== s0 || err_ovr !== 1'b0) begin
         errors++; $display("FAIL er1_no_errors: short %0d ovr %b expected 0 0", short_cnt - s0, err_ovr); end
      checks++; if (cap_cnt - c0 !== 1 || cap_sel !== 1'b0) begin
         errors++; $display("FAIL er1_capture: acks %0d sel %b expected 1 0", cap_cnt - c0, cap_sel); end
      checks++; if (t1[31:0] !== 32'h1357_9BDF) begin errors++; $display("FAIL er1_tdo: got %h expected 13579bdf", t1[31:0]); end
   endtask

   task automatic test_capture_er2;
      logic [63:0] t1, t2; int lat, c0;
      upd_ready = 1'b1;
      cap_data  = {32'h1234_5678, 32'hA5A5_A5A5};
      c0 = cap_cnt;
      scan(1'b1, 1'b0, 32, 64'hC3C3_0F0F, 0, t1, t2, lat);
      checks++; if (cap_cnt - c0 !== 1 || cap_sel !== 1'b1) begin
         errors++; $display("FAIL er2_capture: acks %0d sel %b expected 1 1", cap_cnt - c0, cap_sel); end
      checks++; if (t1[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL er2_tdo1: got %h expected 12345678", t1[31:0]); end
      checks++; if (t2[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL er2_tdo2: got %h expected 12345678", t2[31:0]); end
      checks++; if (acc_data !== 32'hC3C3_0F0F || acc_sel !== 1'b1) begin
         errors++; $display("FAIL er2_update: got %h sel %b expected c3c30f0f sel 1", acc_data, acc_sel); end
      cap_data = {32'h8765_4321, 32'h0F0F_0F0F};
      scan(1'b1, 1'b1, 32, 64'h0000_0003, 0, t1, t2, lat);
      checks++; if (t1[31:0] !== 32'h8765_4321 || cap_sel !== 1'b1) begin
         errors++; $display("FAIL both_ce_priority: tdo %h sel %b expected 87654321 sel 1", t1[31:0], cap_sel); end
   endtask

   task automatic test_overrun;
      logic [63:0] t1, t2; int lat, a0;
      upd_ready = 1'b0;
      a0 = acc_cnt;
      scan(1'b0, 1'b0, 32, 64'h1, 0, t1, t2, lat);
      scan(1'b0, 1'b0, 32, 64'h2, 0, t1, t2, lat);
      checks++; if (upd_valid !== 1'b1 || upd_data !== 32'h1 || upd_sel !== 1'b0) begin
         errors++; $display("FAIL ovr_hold: valid %b data %h sel %b expected 1 00000001 0", upd_valid, upd_data, upd_sel); end
      checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", err_ovr); end
      checks++; if (acc_cnt !== a0) begin errors++; $display("FAIL ovr_no_accept: got %0d expected 0", acc_cnt - a0); end
      upd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (upd_valid !== 1'b0 || acc_data !== 32'h1) begin
         errors++; $display("FAIL ovr_drain: valid %b data %h expected 0 00000001", upd_valid, acc_data); end
      checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", err_ovr); end
   endtask

   task automatic test_short_long;
      logic [63:0] t1, t2; int lat, a0, s0;
      upd_ready = 1'b1;
      a0 = acc_cnt; s0 = short_cnt;
      scan(1'b0, 1'b0, 20, 64'hF_1234, 0, t1, t2, lat);
      checks++; if (short_cnt - s0 !== 1) begin errors++; $display("FAIL short_pulse: got %0d expected 1", short_cnt - s0); end
      checks++; if (acc_cnt !== a0 || upd_valid !== 1'b0) begin
         errors++; $display("FAIL short_dropped: accepts %0d valid %b expected 0 0", acc_cnt - a0, upd_valid); end
      scan(1'b0, 1'b0, 40, 64'hAB_1234_5678, 0, t1, t2, lat);
      checks++; if (acc_cnt - a0 !== 1 || acc_data !== 32'hAB12_3456) begin
         errors++; $display("FAIL long_last32: accepts %0d data %h expected 1 ab123456", acc_cnt - a0, acc_data); end
      checks++; if (short_cnt - s0 !== 1) begin errors++; $display("FAIL long_no_short: got %0d expected 1", short_cnt - s0); end
   endtask

   task automatic test_jrstn;
      logic [63:0] t1, t2; int lat, a0, s0, c0;
      upd_ready = 1'b1;
      a0 = acc_cnt; s0 = short_cnt;
      scan(1'b0, 1'b0, 32, 64'hFFFF_FFFF, 11, t1, t2, lat);
      jrstn = 1'b0;
      repeat (10) @(posedge clk);
      jrstn = 1'b1; jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      c0 = cap_cnt;
      scan(1'b0, 1'b0, 32, 64'h55AA_55AA, 0, t1, t2, lat);
      checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL jrstn_recapture: got %0d expected 1", cap_cnt - c0); end
      checks++; if (acc_cnt - a0 !== 1 || acc_data !== 32'h55AA_55AA) begin
         errors++; $display("FAIL jrstn_rescan: accepts %0d data %h expected 1 55aa55aa", acc_cnt - a0, acc_data); end
      checks++; if (short_cnt !== s0) begin errors++; $display("FAIL jrstn_no_short: got %0d expected 0", short_cnt - s0); end
   endtask

   task automatic test_rst_mid_shift;
      logic [63:0] t1, t2; int lat, a0, c0;
      upd_ready = 1'b0;
      scan(1'b1, 1'b0, 32, 64'h9, 0, t1, t2, lat);
      checks++; if (upd_valid !== 1'b1 || upd_data !== 32'h9) begin
         errors++; $display("FAIL rst_pre_state: valid %b data %h expected 1 00000009", upd_valid, upd_data); end
      scan(1'b0, 1'b0, 32, 64'hFFFF_FFFF, 6, t1, t2, lat);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if ({cap_ack, cap_sel, upd_sel, upd_valid, err_short, err_ovr, jtdo1, jtdo2} !== 8'h00) begin
         errors++; $display("FAIL rst_mid_flags: got %b expected 00000000",
            {cap_ack, cap_sel, upd_sel, upd_valid, err_short, err_ovr, jtdo1, jtdo2}); end
      checks++; if (upd_data !== '0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", upd_data); end
      rst = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0; jtck = 1'b0; upd_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      a0 = acc_cnt; c0 = cap_cnt;
      scan(1'b0, 1'b0, 32, 64'h0F1E_2D3C, 0, t1, t2, lat);
      checks++; if (cap_cnt - c0 !== 1 || acc_cnt - a0 !== 1 || acc_data !== 32'h0F1E_2D3C) begin
         errors++; $display("FAIL rst_rescan: caps %0d accepts %0d data %h expected 1 1 0f1e2d3c",
            cap_cnt - c0, acc_cnt - a0, acc_data); end
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL rst_rescan_ovr: got %b expected 0", err_ovr); end
   endtask

   initial begin
      test_reset();
      test_er1_write();
      test_capture_er2();
      test_overrun();
      test_short_long();
      test_jrstn();
      test_rst_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
